// File: rtl/cga_pkg.sv
// Shared timing constants for the CGA 2x scandoubler sequencer.
// Counts are in 28.6364 MHz clk cycles; the fast line is half an input line.
package cga_pkg;
    localparam int ADDR_W    = 10;
    localparam int LINE_CLKS = 912;
    localparam int HS_START  = 720;
    localparam int HS_END    = 880;
    localparam int ACT_END   = 640;
    localparam int TIMEOUT   = 4095;
    localparam int WD_W      = 12;
endpackage

// File: rtl/scan_wrap_counter.sv
// Up-counter with synchronous clear and enable; at its last value it either wraps to 0
// or holds there (SATURATE). wrap flags the last value.
module scan_wrap_counter #(
    parameter int WIDTH    = 10,
    parameter int MODULO   = 912,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] count_next;

    assign wrap = (count == LAST);

    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            if (!wrap) begin
                count_next = count + 1'b1;
            end else if (!SATURATE) begin
                count_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end
endmodule

// File: rtl/cga_scandoubler_ctrl.sv
// Line-doubling sequencer: input hsync edge detect, ping-pong bank select, half-rate write
// and full-rate read addressing, doubled sync/blank generation and a loss-of-sync watchdog.
module cga_scandoubler_ctrl
    import cga_pkg::*;
#(
    parameter int ADDR_W    = cga_pkg::ADDR_W,
    parameter int LINE_CLKS = cga_pkg::LINE_CLKS,
    parameter int HS_START  = cga_pkg::HS_START,
    parameter int HS_END    = cga_pkg::HS_END,
    parameter int ACT_END   = cga_pkg::ACT_END,
    parameter int TIMEOUT   = cga_pkg::TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic              bank_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              dbl_hsync,
    output logic              dbl_vsync,
    output logic              dbl_blank,
    output logic              locked
);
    localparam logic [ADDR_W-1:0] WR_LAST = '1;

    logic              hs_old;
    logic              phase;
    logic              line_evt;
    logic              rd_wrap;
    logic [ADDR_W-1:0] rd_next;
    logic [WD_W-1:0]   wd_cnt;
    logic              wd_wrap;
    logic              locked_next;
    logic              blank_next;

    assign line_evt = hsync_in & ~hs_old;

    scan_wrap_counter #(
        .WIDTH   (ADDR_W),
        .MODULO  (LINE_CLKS),
        .SATURATE(1'b0)
    ) u_fast_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (line_evt),
        .en   (1'b1),
        .count(rd_addr),
        .wrap (rd_wrap)
    );

    scan_wrap_counter #(
        .WIDTH   (WD_W),
        .MODULO  (TIMEOUT + 1),
        .SATURATE(1'b1)
    ) u_watchdog (
        .clk  (clk),
        .reset(reset),
        .clr  (line_evt),
        .en   (1'b1),
        .count(wd_cnt),
        .wrap (wd_wrap)
    );

    wd_sat_value: assert property (@(posedge clk) disable iff (reset)
        wd_wrap |-> (wd_cnt == WD_W'(TIMEOUT)));

    // Blank is registered from the next-cycle count so it lines up with rd_addr itself.
    assign rd_next     = (line_evt || rd_wrap) ? '0 : rd_addr + 1'b1;
    assign locked_next = line_evt ? 1'b1 : (wd_wrap ? 1'b0 : locked);
    assign blank_next  = ~locked_next | (rd_next >= ADDR_W'(ACT_END));

    assign wr_en = locked & phase & (wr_addr != WR_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_old    <= 1'b0;
            phase     <= 1'b0;
            bank_sel  <= 1'b0;
            wr_addr   <= '0;
            locked    <= 1'b0;
            dbl_hsync <= 1'b0;
            dbl_vsync <= 1'b0;
            dbl_blank <= 1'b1;
        end else begin
            hs_old    <= hsync_in;
            locked    <= locked_next;
            dbl_blank <= blank_next;
            if (line_evt) begin
                phase    <= 1'b0;
                wr_addr  <= '0;
                bank_sel <= ~bank_sel;
            end else begin
                phase <= ~phase;
                if (phase && (wr_addr != WR_LAST)) begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
            // Doubled hsync free-runs off the fast count, even while unlocked.
            if (rd_addr == ADDR_W'(HS_START)) begin
                dbl_hsync <= 1'b1;
            end else if (rd_addr == ADDR_W'(HS_END)) begin
                dbl_hsync <= 1'b0;
            end
            if (line_evt || rd_wrap) begin
                dbl_vsync <= vsync_in;
            end
        end
    end
endmodule
